// File: rtl/parity_engine.sv
// Serial parity checker: accumulates LSB-first data bits, then compares the optional parity bit.
// Optional saturating error counter (port ParEng_ErrCnt) enabled by macro PARITY_ERR_COUNT_EN.
module parity_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ParEng_Start,
    input  logic       ParEng_BitValid,
    input  logic       ParEng_SerBit,
    input  logic       ParEng_ParEn,
    input  logic [1:0] ParEng_Mode,
    output logic       ParEng_ParBit,
    output logic       ParEng_Busy,
    output logic       ParEng_Done,
    output logic       ParEng_ParErr
`ifdef PARITY_ERR_COUNT_EN
    ,
    output logic [7:0] ParEng_ErrCnt
`endif
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PAR    = 2'd2;
    localparam logic [1:0] REPORT = 2'd3;

    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(DATA_WIDTH - 1);

    logic [1:0]           state;
    logic                 acc;
    logic [CNT_WIDTH-1:0] bitCnt;
    logic [1:0]           modeHeld;
    logic                 parEnHeld;
    logic                 parErr;
    logic                 parBit;

    // Parity follows the mode captured at Start, not the live Mode input.
    always_comb begin
        parBit = 1'b0;
        case (modeHeld)
            2'b00:   parBit = acc;
            2'b01:   parBit = ~acc;
            2'b10:   parBit = 1'b1;
            default: parBit = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            acc       <= 1'b0;
            bitCnt    <= '0;
            modeHeld  <= 2'b00;
            parEnHeld <= 1'b0;
            parErr    <= 1'b0;
        end else if (ParEng_Start) begin
            state     <= DATA;
            acc       <= 1'b0;
            bitCnt    <= '0;
            modeHeld  <= ParEng_Mode;
            parEnHeld <= ParEng_ParEn;
            parErr    <= 1'b0;
        end else begin
            case (state)
                DATA: begin
                    if (ParEng_BitValid) begin
                        acc    <= acc ^ ParEng_SerBit;
                        bitCnt <= bitCnt + CNT_WIDTH'(1);
                        if (bitCnt == LAST_BIT) begin
                            state <= parEnHeld ? PAR : REPORT;
                        end
                    end
                end
                PAR: begin
                    if (ParEng_BitValid) begin
                        parErr <= (ParEng_SerBit != parBit);
                        state  <= REPORT;
                    end
                end
                REPORT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ParEng_ParBit = parBit;
    assign ParEng_Busy   = (state == DATA) || (state == PAR);
    assign ParEng_Done   = (state == REPORT);
    assign ParEng_ParErr = parErr;

`ifdef PARITY_ERR_COUNT_EN
    logic [7:0] errCnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            errCnt <= '0;
        end else if ((state == REPORT) && parErr && (errCnt != '1)) begin
            errCnt <= errCnt + 8'd1;
        end
    end

    assign ParEng_ErrCnt = errCnt;
`else
    // No error counter in this configuration.
`endif

endmodule
